// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone round-robin arbiter.
// Holds the FSM encoding and the watchdog counter width.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int CNT_W = 16;

endpackage

// File: rtl/wb_watchdog.sv
// Strobe watchdog: counts unterminated strobe cycles and pulses
// abort_o for one cycle when the count reaches TIMEOUT.
module wb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic en_i,
    input  logic stb_i,
    input  logic term_i,
    output logic abort_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic WD_ON = (TIMEOUT != 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A termination in the limit cycle wins over the abort.
    always_comb begin
        abort_o = WD_ON && en_i && stb_i && !term_i
                  && (cnt_q == LIMIT);
        cnt_d = cnt_q;
        if (!WD_ON || !en_i || term_i || abort_o) begin
            cnt_d = '0;
        end else if (stb_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter with round-robin
// grant held for the whole cycle and a hung-access watchdog.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              rst_n,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic              m0_we_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic              m0_rty_o,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic              m1_we_i,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              m1_rty_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic              s_we_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic              s_rty_i,
    output logic [1:0]        gnt_o,
    output logic              timeout_o
);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] gnt_q;
    logic [1:0] gnt_d;
    logic       last_q;
    logic       last_d;

    logic            busy;
    logic            g1;
    logic [AW-1:0]   m_adr;
    logic [DW-1:0]   m_dat;
    logic [DW/8-1:0] m_sel;
    logic            m_we;
    logic            m_cyc;
    logic            m_stb;
    logic            term;
    logic            abort;

    assign busy = (state_q == BUSY);
    assign g1   = gnt_q[1];

    assign m_adr = g1 ? m1_adr_i : m0_adr_i;
    assign m_dat = g1 ? m1_dat_i : m0_dat_i;
    assign m_sel = g1 ? m1_sel_i : m0_sel_i;
    assign m_we  = g1 ? m1_we_i  : m0_we_i;
    assign m_cyc = busy & (g1 ? m1_cyc_i : m0_cyc_i);
    assign m_stb = m_cyc & (g1 ? m1_stb_i : m0_stb_i);
    assign term  = s_ack_i | s_err_i | s_rty_i;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i   (wb_clk_i),
        .rst_n   (rst_n),
        .en_i    (m_cyc),
        .stb_i   (m_stb),
        .term_i  (term),
        .abort_o (abort)
    );

    assign s_adr_o = busy ? m_adr : '0;
    assign s_dat_o = busy ? m_dat : '0;
    assign s_sel_o = busy ? m_sel : '0;
    assign s_we_o  = busy & m_we;
    assign s_cyc_o = m_cyc & ~abort;
    assign s_stb_o = m_stb & ~abort;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign m0_ack_o = m_cyc & ~g1 & s_ack_i;
    assign m0_err_o = m_cyc & ~g1 & (s_err_i | abort);
    assign m0_rty_o = m_cyc & ~g1 & s_rty_i;
    assign m1_ack_o = m_cyc & g1 & s_ack_i;
    assign m1_err_o = m_cyc & g1 & (s_err_i | abort);
    assign m1_rty_o = m_cyc & g1 & s_rty_i;

    assign gnt_o     = gnt_q;
    assign timeout_o = abort;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i || m1_cyc_i) begin
                    state_d = BUSY;
                    // On contention the master that did not go last wins.
                    if (m0_cyc_i && m1_cyc_i) begin
                        gnt_d = last_q ? 2'b01 : 2'b10;
                    end else begin
                        gnt_d = m1_cyc_i ? 2'b10 : 2'b01;
                    end
                end
            end
            BUSY: begin
                if (!m_cyc) begin
                    state_d = IDLE;
                    last_d  = g1;
                    gnt_d   = 2'b00;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with per-master and slave-side
// expectation queues and a simple latency-programmable slave.
module tb_wb_rr_arbiter;

    typedef struct {
        logic        is_err;
        logic        rd;
        logic [31:0] dat;
    } mexp_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } sexp_t;

    logic        wb_clk_i;
    logic        rst_n;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_we_i, m0_cyc_i, m0_stb_i;
    logic        m1_we_i, m1_cyc_i, m1_stb_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o;
    logic        m1_ack_o, m1_err_o, m1_rty_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic        s_ack_i, s_err_i, s_rty_i;
    logic [1:0]  gnt_o;
    logic        timeout_o;

    int          vectors = 0;
    int          miscompares = 0;
    int          lat = 0;
    logic [31:0] rd_base = '0;
    mexp_t       q0[$];
    mexp_t       q1[$];
    sexp_t       sq[$];

    wb_rr_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(16)
    ) dut (
        .wb_clk_i(wb_clk_i), .rst_n(rst_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge wb_clk_i);
    endtask

    task automatic drv(input int m, input logic cyc, input logic stb,
                       input logic [31:0] adr, input logic [31:0] dat,
                       input logic we, input logic [3:0] sel);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_adr_i = adr;
            m0_dat_i = dat; m0_we_i = we; m0_sel_i = sel;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_adr_i = adr;
            m1_dat_i = dat; m1_we_i = we; m1_sel_i = sel;
        end
    endtask

    task automatic exp_m(input int m, input logic is_err,
                         input logic rd, input logic [31:0] dat);
        mexp_t e;
        e.is_err = is_err; e.rd = rd; e.dat = dat;
        if (m == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic exp_s(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        sexp_t e;
        e.we = we; e.adr = adr; e.dat = dat; e.sel = sel;
        sq.push_back(e);
    endtask

    function automatic logic mterm(input int m);
        return (m == 0) ? (m0_ack_o | m0_err_o) : (m1_ack_o | m1_err_o);
    endfunction

    task automatic wait_term(input int m, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            sample();
            ok = mterm(m);
        end
        if (!ok) chk($sformatf("m%0d_wait_term", m), 0, 1);
    endtask

    task automatic access(input int m, input logic [31:0] adr,
                          input logic [31:0] dat, input logic we,
                          input logic [3:0] sel, input bit keep);
        drv(m, 1'b1, 1'b1, adr, dat, we, sel);
        wait_term(m, 64);
        chk($sformatf("m%0d_gnt_at_term", m), gnt_o,
            (m == 0) ? 2'b01 : 2'b10);
        step();
        drv(m, keep, 1'b0, adr, dat, we, sel);
    endtask

    task automatic mon(input int m, input logic ack, input logic err,
                       input logic [31:0] dat);
        mexp_t e;
        if (ack || err) begin
            if ((m == 0 ? q0.size() : q1.size()) == 0) begin
                chk($sformatf("m%0d_unexpected_term", m), {ack, err}, 0);
            end else begin
                if (m == 0) e = q0.pop_front();
                else e = q1.pop_front();
                chk($sformatf("m%0d_term_kind", m), {ack, err},
                    e.is_err ? 2'b01 : 2'b10);
                if (e.rd && !e.is_err)
                    chk($sformatf("m%0d_rd_data", m), dat, e.dat);
            end
        end
    endtask

    initial begin : monitor
        forever begin
            sample();
            if (rst_n) begin
                mon(0, m0_ack_o, m0_err_o, m0_dat_o);
                mon(1, m1_ack_o, m1_err_o, m1_dat_o);
                if (mterm(0) && mterm(1)) chk("both_terminated", 1, 0);
            end
        end
    end

    initial begin : slave
        int    wcnt;
        logic  req;
        sexp_t e;
        wcnt = 0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = '0;
        forever begin
            @(posedge wb_clk_i);
            #2;
            req = (gnt_o[0] && m0_cyc_i && m0_stb_i)
                  || (gnt_o[1] && m1_cyc_i && m1_stb_i);
            s_ack_i = 1'b0;
            if (req && lat >= 0 && wcnt == lat) begin
                s_ack_i = 1'b1;
                s_dat_i = rd_base ^ s_adr_o;
                wcnt = 0;
                #1;
                chk("slv_cyc_stb_at_ack", {s_cyc_o, s_stb_o}, 2'b11);
                if (sq.size() == 0) begin
                    chk("slv_unexpected_access", 1, 0);
                end else begin
                    e = sq.pop_front();
                    chk("slv_we", s_we_o, e.we);
                    chk("slv_adr", s_adr_o, e.adr);
                    chk("slv_sel", s_sel_o, e.sel);
                    if (e.we) chk("slv_wdat", s_dat_o, e.dat);
                end
            end else if (req) begin
                wcnt++;
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin : time_limit
        #200000;
        $display("FAIL sim_time_limit: observed no finish expected finish");
        $fatal(1);
    end

    initial begin : main
        bit early;
        rst_n = 1'b0;
        drv(0, 1'b0, 1'b0, '0, '0, 1'b0, 4'h0);
        drv(1, 1'b0, 1'b0, '0, '0, 1'b0, 4'h0);
        repeat (2) step();
        sample();
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_slave", {s_cyc_o, s_stb_o, s_we_o, s_adr_o}, 0);
        chk("rst_mresp", {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o,
                          m1_err_o, m1_rty_o, timeout_o}, 0);
        step();
        rst_n = 1'b1;
        step();

        // contention straight after reset
        lat = 0;
        rd_base = 32'h1111_0000;
        exp_m(0, 0, 1, rd_base ^ 32'h10);
        exp_m(1, 0, 1, rd_base ^ 32'h20);
        exp_m(0, 0, 1, rd_base ^ 32'h14);
        exp_m(1, 0, 1, rd_base ^ 32'h24);
        exp_s(0, 32'h10, 0, 4'hF);
        exp_s(0, 32'h20, 0, 4'h3);
        exp_s(0, 32'h14, 0, 4'hF);
        exp_s(0, 32'h24, 0, 4'h3);
        drv(0, 1, 1, 32'h10, 0, 0, 4'hF);
        drv(1, 1, 1, 32'h20, 0, 0, 4'h3);
        sample(); chk("c_gnt_latency", gnt_o, 2'b00);
        step(); sample(); chk("c_first_m0", gnt_o, 2'b01);
        step(); drv(0, 0, 0, 32'h10, 0, 0, 4'hF);
        sample(); chk("c_release_cyc", {s_cyc_o, gnt_o}, 3'b001);
        step(); sample(); chk("c_idle_gap", gnt_o, 2'b00);
        step(); sample(); chk("c_then_m1", {gnt_o, s_adr_o[7:0], s_sel_o},
                              {2'b10, 8'h20, 4'h3});
        step();
        drv(1, 0, 0, 32'h20, 0, 0, 4'h3);
        drv(0, 1, 1, 32'h14, 0, 0, 4'hF);
        sample(); chk("c_waiter_hidden", {s_cyc_o, gnt_o}, 3'b010);
        step(); drv(1, 1, 1, 32'h24, 0, 0, 4'h3);
        sample(); chk("c_idle2", gnt_o, 2'b00);
        step(); sample(); chk("c_rr_m0_again", gnt_o, 2'b01);
        step(); drv(0, 0, 0, 32'h14, 0, 0, 4'hF);
        step(); sample(); chk("c_idle3", gnt_o, 2'b00);
        step(); sample(); chk("c_rr_m1_again", gnt_o, 2'b10);
        step(); drv(1, 0, 0, 32'h24, 0, 0, 4'h3);
        step();

        // single m0 read, slave acks after two wait cycles
        lat = 2;
        rd_base = 32'hDEAD_BEEF ^ 32'h100;
        exp_m(0, 0, 1, 32'hDEAD_BEEF);
        exp_s(0, 32'h100, 0, 4'hF);
        drv(0, 1, 1, 32'h100, 0, 0, 4'hF);
        sample(); chk("r_scyc_not_yet", s_cyc_o, 1'b0);
        step(); sample();
        chk("r_scyc_rise", {s_cyc_o, s_stb_o, gnt_o}, 4'b1101);
        chk("r_sadr", s_adr_o, 32'h100);
        wait_term(0, 16);
        chk("r_m0_data", {m0_ack_o, m0_dat_o}, {1'b1, 32'hDEAD_BEEF});
        chk("r_m1_quiet", {m1_ack_o, m1_err_o}, 2'b00);
        step(); drv(0, 0, 0, 32'h100, 0, 0, 4'hF);
        step();

        // m1 burst of writes while m0 requests
        lat = 1;
        rd_base = 32'h0;
        for (int i = 0; i < 4; i++) begin
            exp_m(1, 0, 0, 0);
            exp_s(1, 32'(i * 4), 32'hB000_0000 + 32'(i), 4'hF);
        end
        exp_m(0, 0, 1, 32'h300);
        exp_s(0, 32'h300, 0, 4'hF);
        fork
            begin
                for (int i = 0; i < 4; i++)
                    access(1, 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b1,
                           4'hF, i < 3);
            end
            begin
                step(); step();
                access(0, 32'h300, 0, 1'b0, 4'hF, 1'b0);
            end
        join
        step();

        // watchdog fires on a hung strobe
        lat = -1;
        exp_m(0, 1, 1, 0);
        drv(0, 1, 1, 32'h400, 0, 0, 4'hF);
        sample();
        early = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step(); sample();
            if (m0_err_o || timeout_o || !s_stb_o) early = 1'b1;
        end
        chk("wd_not_early", early, 1'b0);
        step(); sample();
        chk("wd_fire", {m0_err_o, timeout_o, m1_err_o}, 3'b110);
        chk("wd_slave_off", {s_cyc_o, s_stb_o}, 2'b00);
        chk("wd_keeps_gnt", gnt_o, 2'b01);
        step(); drv(0, 0, 0, 32'h400, 0, 0, 4'hF);
        step();
        lat = 1;
        rd_base = 32'h0BAD_F00D;
        exp_m(0, 0, 1, rd_base ^ 32'h404);
        exp_s(0, 32'h404, 0, 4'hF);
        access(0, 32'h404, 0, 1'b0, 4'hF, 1'b0);
        step();

        // ack in the very cycle the count reaches the limit
        lat = 16;
        rd_base = 32'h5555_0000;
        exp_m(0, 0, 1, rd_base ^ 32'h408);
        exp_s(0, 32'h408, 0, 4'hF);
        drv(0, 1, 1, 32'h408, 0, 0, 4'hF);
        early = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step(); sample();
            if (m0_ack_o || m0_err_o || timeout_o) early = 1'b1;
        end
        chk("ackwin_not_early", early, 1'b0);
        step(); sample();
        chk("ackwin", {m0_ack_o, m0_err_o, timeout_o}, 3'b100);
        step(); drv(0, 0, 0, 32'h408, 0, 0, 4'hF);
        step();

        // asynchronous reset during an m1 write
        lat = -1;
        drv(1, 1, 1, 32'h500, 32'hCAFE, 1, 4'hF);
        step(); sample();
        chk("rst_mid_busy", {s_cyc_o, gnt_o}, 3'b110);
        @(posedge wb_clk_i);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_drop", {s_cyc_o, s_stb_o, gnt_o}, 4'b0000);
        drv(1, 0, 0, 32'h500, 32'hCAFE, 1, 4'hF);
        step(); step();
        rst_n = 1'b1;
        step();
        lat = 0;
        rd_base = 32'h7777_0000;
        exp_m(0, 0, 1, rd_base ^ 32'h600);
        exp_s(0, 32'h600, 0, 4'hF);
        drv(0, 1, 1, 32'h600, 0, 0, 4'hF);
        drv(1, 1, 1, 32'h604, 0, 0, 4'hF);
        sample(); chk("post_rst_idle", gnt_o, 2'b00);
        step(); sample(); chk("post_rst_m0_first", gnt_o, 2'b01);
        step();
        drv(0, 0, 0, 32'h600, 0, 0, 4'hF);
        drv(1, 0, 0, 32'h604, 0, 0, 4'hF);
        step(); step();

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("slave_q_drained", sq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter.
- Lets the picorv32 core and a second master (debug loader or DMA) share one slave port, typically a RAM or intercon slave.
- Grants round-robin, holds the grant for the whole cyc, and adds a watchdog that terminates a hung access with err.

Parameters:
- AW, 32, address width.
- DW, 32, data width; sel width is DW/8.
- TIMEOUT, 255, unterminated-strobe cycles before forced err; 0 disables the watchdog; maximum 65535.

Ports:
- wb_clk_i  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- m0_adr_i, m1_adr_i  in  AW  master address.
- m0_dat_i, m1_dat_i  in  DW  master write data.
- m0_sel_i, m1_sel_i  in  DW/8  byte selects.
- m0_we_i, m1_we_i  in  1  write enable.
- m0_cyc_i, m1_cyc_i  in  1  cycle request.
- m0_stb_i, m1_stb_i  in  1  strobe.
- m0_dat_o, m1_dat_o  out  DW  read data (s_dat_i broadcast to both).
- m0_ack_o, m1_ack_o  out  1  ack.
- m0_err_o, m1_err_o  out  1  error.
- m0_rty_o, m1_rty_o  out  1  retry.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave error.
- s_rty_i  in  1  slave retry.
- gnt_o  out  2  one-hot current grant; 00 when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Clocking/reset: single clock wb_clk_i; reset asynchronous, active-low (rst_n).
- Reset values:
  - state IDLE, gnt_o 00, last 1 (so m0 wins the first contention), watchdog count 0.
  - All s_* outputs 0.
  - All m*_ack/err/rty 0, timeout_o 0.
- States: IDLE, BUSY, both registered.
- IDLE:
  - Slave outputs all 0.
  - If any m*_cyc_i, next state BUSY.
  - Grant: sole requester wins; if both request, the master other than `last` wins.
  - Grant latency is one cycle from cyc to s_cyc_o.
- BUSY with granted master g:
  - s_adr/dat/sel/we/cyc/stb are combinational copies of m{g} inputs.
  - s_ack/err/rty are routed to m{g} only; the other master's ack/err/rty are held 0.
  - Grant persists across multiple stb phases while m{g}_cyc_i stays 1 (burst/RMW safe).
- Release:
  - On the cycle m{g}_cyc_i==0, s_cyc_o is already 0 (combinational).
  - Next state IDLE; last<=g; gnt_o<=00.
  - No back-to-back regrant in the same cycle; minimum one IDLE cycle between owners.
- Watchdog (TIMEOUT>0), 16-bit counter cnt:
  - cnt increments each cycle s_stb_o && !(s_ack_i|s_err_i|s_rty_i).
  - cnt clears on any termination, on cyc drop, and in IDLE.
  - When cnt==TIMEOUT: s_cyc_o and s_stb_o are forced 0 that cycle, m{g}_err_o=1, timeout_o=1, cnt<=0.
  - The master keeps the grant until it drops cyc.
  - With strobe first asserted in cycle 0, err appears in cycle TIMEOUT.
- Simultaneous events:
  - Slave ack in the same cycle cnt==TIMEOUT: ack wins, no err, cnt clears.
  - Non-granted master raising cyc during BUSY waits; no effect on the slave.
- Reset asserted mid-transfer: all outputs 0 immediately (asynchronous); the master must reissue its access.
- No combinational path from m{g}_cyc_i to gnt_o; gnt_o is registered.

Decomposition:
- Shared package wb_arb_pkg:
  - state encoding (IDLE=1'b0, BUSY=1'b1).
  - TIMEOUT counter width constant (16).
- One natural sub-module: wb_watchdog, holding the counter, compare and abort pulse.
- Muxing and FSM stay in the top module.

Test Plan:
- Reset, then m0 cyc/stb read at 0x100, slave acks in 2 cycles with 0xDEADBEEF:
  - s_cyc_o rises 1 cycle after m0_cyc_i.
  - m0_dat_o=0xDEADBEEF with m0_ack_o; m1_ack_o stays 0.
- Both masters raise cyc in the same cycle after reset:
  - m0 granted first (gnt_o=01).
  - After m0 drops cyc, one IDLE cycle, then gnt_o=10.
  - Repeat contention: m0 wins again only after m1 is served.
- m1 burst of 4 writes (adr 0x0,0x4,0x8,0xC, sel 4'hF) holding cyc while m0 requests:
  - All 4 reach the slave unbroken; m0 granted only after m1 drops cyc.
- TIMEOUT=16, slave never acks m0 strobe:
  - m0_err_o and timeout_o high exactly in cycle 16, s_stb_o low that cycle.
  - Next access with ack works normally.
- Slave acks exactly in the cycle cnt==TIMEOUT:
  - m0_ack_o=1, m0_err_o=0, timeout_o=0.
- rst_n pulsed low mid-write by m1:
  - s_cyc_o, s_stb_o and gnt_o drop to 0 without waiting for a clock edge.
  - After release, m0 wins the first contention.
